// File: rtl/rgb_color_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pkg
// Purpose  : Shared palette constants, FSM state type and index width for the
//            RGB colour sequencer.
// Revision : 1.0
// ============================================================================
package rgb_pkg;

    localparam int IDX_W = 2;

    localparam logic [23:0] PAL_WHITE   = 24'h3F3F3F;
    localparam logic [23:0] PAL_RED     = 24'h7F0000;
    localparam logic [23:0] PAL_GREEN   = 24'h007F00;
    localparam logic [23:0] PAL_BLUE    = 24'h00007F;
    localparam logic [23:0] PAL_DEFAULT = 24'h5F5F5F;

    typedef enum logic [1:0] {
        MANUAL   = 2'd0,
        AUTO     = 2'd1,
        OVERRIDE = 2'd2
    } state_t;

    function automatic logic [23:0] palette_color(input logic [IDX_W-1:0] idx);
        logic [23:0] color;
        case (idx)
            2'd0:    color = PAL_WHITE;
            2'd1:    color = PAL_RED;
            2'd2:    color = PAL_GREEN;
            default: color = PAL_BLUE;
        endcase
        return color;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_color_sequencer_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : Two-flop synchroniser followed by a consecutive-cycle debounce
//            filter for one raw push-button.
// Revision : 1.0
// ============================================================================
module button_debouncer
    import rgb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_btn_db
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Counter only runs while the synchronised level disagrees with the
    // accepted one; a single agreeing cycle restarts the qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_btn_db = r_db;

endmodule
`default_nettype wire

// File: rtl/rgb_color_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_color_sequencer
// Purpose  : Debounced-button / auto-dwell palette sequencer producing the
//            registered 24-bit colour word for the LED PWM path.
// Revision : 1.0
// ============================================================================
module rgb_color_sequencer
    import rgb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int DWELL_CYCLES    = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_next,
    input  logic             btn_default,
    input  logic             auto_en,
    output logic [23:0]      RGBcolor,
    output logic [IDX_W-1:0] color_idx,
    output logic             rgb_update
);

    localparam int              DW_W         = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0] c_dwell_last = DW_W'(DWELL_CYCLES - 1);

    logic             w_next_db;
    logic             w_def_db;
    logic             r_auto_s1;
    logic             r_auto_s2;
    logic             r_next_prev;
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [DW_W-1:0]  r_dwell;
    logic [23:0]      r_rgb;
    logic             r_upd;

    logic             w_next_evt;
    state_t           w_state_nxt;
    logic             w_expired;
    logic             w_adv;
    logic [23:0]      w_rgb_nxt;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_next (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (btn_next),
        .o_btn_db (w_next_db)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_default (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (btn_default),
        .o_btn_db (w_def_db)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_auto_s1 <= auto_en;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // Advance is qualified on the state being entered, so a press arriving in
    // the same cycle the override engages is already discarded.
    always_comb begin
        w_next_evt = w_next_db & ~r_next_prev;
        if (w_def_db) begin
            w_state_nxt = OVERRIDE;
        end else if (r_auto_s2) begin
            w_state_nxt = AUTO;
        end else begin
            w_state_nxt = MANUAL;
        end
        w_expired = (r_state == AUTO) && (w_state_nxt == AUTO) &&
                    (r_dwell == c_dwell_last);
        w_adv     = (w_state_nxt != OVERRIDE) && (w_next_evt || w_expired);
        w_rgb_nxt = (r_state == OVERRIDE) ? PAL_DEFAULT : palette_color(r_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MANUAL;
            r_next_prev <= 1'b0;
            r_idx       <= '0;
            r_dwell     <= '0;
            r_rgb       <= PAL_WHITE;
            r_upd       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_next_prev <= w_next_db;
            if (w_adv) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (((w_state_nxt == AUTO) && (r_state != AUTO)) || w_adv) begin
                r_dwell <= '0;
            end else if (w_state_nxt == AUTO) begin
                r_dwell <= r_dwell + DW_W'(1);
            end
            r_rgb <= w_rgb_nxt;
            r_upd <= (w_rgb_nxt != r_rgb);
        end
    end

    assign RGBcolor   = r_rgb;
    assign color_idx  = r_idx;
    assign rgb_update = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_rgb_color_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_color_sequencer
// Purpose  : Directed plus randomized self-checking bench for
//            rgb_color_sequencer against a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rgb_color_sequencer;

    localparam int DB = 4;
    localparam int DW = 8;
    localparam logic [23:0] DEF_COLOR = 24'h5F5F5F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_default = 1'b0;
    logic        auto_en = 1'b0;
    logic [23:0] RGBcolor;
    logic [1:0]  color_idx;
    logic        rgb_update;

    rgb_color_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .DWELL_CYCLES   (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn_next),
        .btn_default(btn_default),
        .auto_en    (auto_en),
        .RGBcolor   (RGBcolor),
        .color_idx  (color_idx),
        .rgb_update (rgb_update)
    );

    always #5 clk = ~clk;

    logic [23:0] pal [4] = '{24'h3F3F3F, 24'h7F0000, 24'h007F00, 24'h00007F};

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int upd_cnt = 0;
    int chg_cnt = 0;
    logic [1:0] prev_idx = 2'd0;

    // Reference model: mode 0 = manual, 1 = auto, 2 = override.
    bit          m_s1 [3];
    bit          m_s2 [3];
    bit          m_db [2];
    int          m_run [2];
    bit          m_db_prev;
    int          m_mode;
    int          m_deadline;
    int          m_idx;
    logic [23:0] m_rgb;
    bit          m_upd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 1'b0;
            m_s2[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            m_db[i]  = 1'b0;
            m_run[i] = 0;
        end
        m_db_prev  = 1'b0;
        m_mode     = 0;
        m_deadline = 0;
        m_idx      = 0;
        m_rgb      = pal[0];
        m_upd      = 1'b0;
    endfunction

    function automatic void model_step();
        bit          evt;
        bit          expired;
        bit          adv;
        int          tgt;
        logic [23:0] nrgb;
        evt     = m_db[0] && !m_db_prev;
        tgt     = m_db[1] ? 2 : (m_s2[2] ? 1 : 0);
        expired = (m_mode == 1) && (tgt == 1) && (edge_n == m_deadline);
        adv     = (tgt != 2) && (evt || expired);
        nrgb    = (m_mode == 2) ? DEF_COLOR : pal[m_idx];
        m_upd   = (nrgb != m_rgb);
        m_rgb   = nrgb;
        if (adv) m_idx = (m_idx + 1) % 4;
        // Next auto advance falls DW edges after AUTO entry or after any advance.
        if (tgt == 1 && (m_mode != 1 || adv)) m_deadline = edge_n + DW;
        m_mode    = tgt;
        m_db_prev = m_db[0];
        for (int b = 0; b < 2; b++) begin
            if (m_s2[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_db[b]  = m_s2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2    = m_s1;
        m_s1[0] = btn_next;
        m_s1[1] = btn_default;
        m_s1[2] = auto_en;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (!rst_n) model_reset();
        else        model_step();
        chk("rgb", 32'(RGBcolor), 32'(m_rgb));
        chk("idx", 32'(color_idx), 32'(m_idx));
        chk("upd", 32'(rgb_update), 32'(m_upd));
        if (rgb_update === 1'b1) upd_cnt++;
        if (color_idx !== prev_idx) chg_cnt++;
        prev_idx = color_idx;
    endtask

    task automatic press_next(input int hold);
        btn_next = 1'b1;
        repeat (hold) tick();
        btn_next = 1'b0;
        repeat (hold) tick();
    endtask

    int exp_seq [5] = '{1, 2, 3, 0, 1};
    int u0;
    int c0;
    int old_idx;
    int tries;

    initial begin
        model_reset();
        // Reset state
        repeat (2) tick();
        chk("reset_rgb", 32'(RGBcolor), 32'h3F3F3F);
        chk("reset_idx", 32'(color_idx), 32'd0);
        chk("reset_upd", 32'(rgb_update), 32'd0);
        rst_n = 1'b1;
        u0 = upd_cnt;
        repeat (10) tick();
        chk("idle_rgb", 32'(RGBcolor), 32'h3F3F3F);
        chk("idle_upd_count", 32'(upd_cnt - u0), 32'd0);

        // Manual cycling
        for (int i = 0; i < 5; i++) begin
            u0 = upd_cnt;
            press_next(10);
            chk("manual_idx", 32'(color_idx), 32'(exp_seq[i]));
            chk("manual_rgb", 32'(RGBcolor), 32'(pal[exp_seq[i]]));
            chk("manual_upd_count", 32'(upd_cnt - u0), 32'd1);
        end

        // Short glitch rejected
        u0 = upd_cnt;
        btn_next = 1'b1;
        repeat (3) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        chk("glitch_idx", 32'(color_idx), 32'd1);
        chk("glitch_upd_count", 32'(upd_cnt - u0), 32'd0);

        // Bounce then stable high: one advance, on the 7th edge of the stable level
        old_idx = 1;
        for (int i = 0; i < 4; i++) begin
            btn_next = (i % 2 == 0);
            tick();
        end
        btn_next = 1'b1;
        c0 = chg_cnt;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 6) chk("bounce_before", 32'(color_idx), 32'(old_idx));
            if (t == 7) chk("bounce_after", 32'(color_idx), 32'((old_idx + 1) % 4));
        end
        btn_next = 1'b0;
        repeat (10) tick();
        chk("bounce_advances", 32'(chg_cnt - c0), 32'd1);

        // Auto mode: AUTO entered on edge 3, advances on edges 11, 19, 27, 35
        auto_en = 1'b1;
        c0 = chg_cnt;
        repeat (40) tick();
        chk("auto_advances", 32'(chg_cnt - c0), 32'd4);
        repeat (4) tick();
        // Press timed so its advance lands on the expiry at edge 51
        btn_next = 1'b1;
        c0 = chg_cnt;
        repeat (7) tick();
        chk("coincide_single", 32'(chg_cnt - c0), 32'd1);
        c0 = chg_cnt;
        repeat (3) tick();
        btn_next = 1'b0;
        repeat (4) tick();
        chk("dwell_restart_quiet", 32'(chg_cnt - c0), 32'd0);
        tick();
        chk("dwell_restart_adv", 32'(chg_cnt - c0), 32'd1);
        auto_en = 1'b0;
        repeat (10) tick();

        // Override at idx 2
        tries = 0;
        while (m_idx != 2 && tries < 5) begin
            press_next(10);
            tries++;
        end
        chk("ovr_start_idx", 32'(color_idx), 32'd2);
        btn_default = 1'b1;
        repeat (8) tick();
        chk("ovr_rgb", 32'(RGBcolor), 32'h5F5F5F);
        press_next(10);
        chk("ovr_hold_idx", 32'(color_idx), 32'd2);
        chk("ovr_hold_rgb", 32'(RGBcolor), 32'h5F5F5F);
        btn_default = 1'b0;
        repeat (8) tick();
        chk("ovr_release_rgb", 32'(RGBcolor), 32'h007F00);
        chk("ovr_release_idx", 32'(color_idx), 32'd2);

        // Reset mid-debounce (count reaches 3 after 5 edges)
        btn_next = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", 32'(RGBcolor), 32'h3F3F3F);
        chk("async_rst_idx", 32'(color_idx), 32'd0);
        chk("async_rst_upd", 32'(rgb_update), 32'd0);
        model_reset();
        prev_idx = color_idx;
        btn_next = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        c0 = chg_cnt;
        repeat (20) tick();
        chk("post_rst_no_adv", 32'(chg_cnt - c0), 32'd0);
        chk("post_rst_idx", 32'(color_idx), 32'd0);

        // Randomized phase checked cycle by cycle against the model
        for (int seg = 0; seg < 60; seg++) begin
            btn_next    = 1'($urandom_range(0, 1));
            btn_default = ($urandom_range(0, 5) == 0);
            auto_en     = ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(1, 14)) tick();
        end
        btn_next    = 1'b0;
        btn_default = 1'b0;
        auto_en     = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
